serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder with carry-in: latches two operands on a start strobe, adds them LSB-first through a single full-adder cell and a registered carry flip-flop, one bit per clock, then presents sum and carry-out with a one-cycle done pulse. It is the additive counterpart to the full-subtractor datapath in the combinational library. It serves as the area-minimal arithmetic building block for sequential designs that can trade latency for gates.

---
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVERFLOW_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             overflow_out,
`endif
  output logic             carry_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr;
  logic             r_cy;
  logic [CW-1:0]    r_cnt;
  logic             r_busy, r_done;
  logic             w_s, w_cy_nxt;

  assign w_s      = r_a_sr[0] ^ r_b_sr[0] ^ r_cy;
  assign w_cy_nxt = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_cy) | (r_b_sr[0] & r_cy);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start_in) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // busy/done are flopped from the next state so they track the state register exactly.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state  <= S_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_cy     <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: if (start_in) begin
          r_a_sr <= a_in;
          r_b_sr <= b_in;
          r_cy   <= c_in;
          r_cnt  <= '0;
        end
        S_RUN: begin
          r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
          r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cy     <= w_cy_nxt;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic r_ovf;
  // On the last bit r_cy is the carry into the MSB and w_cy_nxt the carry out.
  always_ff @(posedge clk_in) begin
    if (rst_in)                                 r_ovf <= 1'b0;
    else if (r_state == S_RUN && r_cnt == LAST) r_ovf <= r_cy ^ w_cy_nxt;
  end
  assign overflow_out = r_ovf;
`endif

  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign sum_out   = r_sum_sr;
  assign carry_out = r_cy;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=32 with hand-computed results.
module tb_serial_adder;

  logic        clk_in = 1'b0;
  logic        rst_in, start_in, c_in;
  logic [7:0]  a_in, b_in, sum_out;
  logic        busy_out, done_out, carry_out;
  logic        s32_start, s32_c;
  logic [31:0] s32_a, s32_b, s32_sum;
  logic        s32_busy, s32_done, s32_carry;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic        overflow_out, s32_ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  serial_adder #(.WIDTH(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy_out(busy_out), .done_out(done_out), .sum_out(sum_out),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow_out(overflow_out),
`endif
    .carry_out(carry_out)
  );

  serial_adder #(.WIDTH(32)) dut32 (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(s32_start),
    .a_in(s32_a), .b_in(s32_b), .c_in(s32_c),
    .busy_out(s32_busy), .done_out(s32_done), .sum_out(s32_sum),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .overflow_out(s32_ovf),
`endif
    .carry_out(s32_carry)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Accept one add on the 8-bit unit; returns cycles to done and busy-cycle count.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      output int cyc, output int nbusy);
    a_in = a; b_in = b; c_in = c; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    cyc = 1; nbusy = 0;
    while (!done_out && cyc < 40) begin
      if (busy_out) nbusy++;
      tick();
      cyc++;
    end
    if (busy_out) nbusy++;
  endtask

  task automatic add32(input logic [31:0] a, input logic [31:0] b, input logic c,
                       input string tag);
    int cyc;
    s32_a = a; s32_b = b; s32_c = c; s32_start = 1'b1;
    tick();
    s32_start = 1'b0;
    cyc = 1;
    while (!s32_done && cyc < 80) begin
      tick();
      cyc++;
    end
    chk({tag, "_lat"}, 64'(cyc), 64'd33);
    chk({tag, "_res"}, {31'd0, s32_carry, s32_sum}, 64'(a) + 64'(b) + 64'(c));
  endtask

  initial begin
    int cyc, nb, t;
    logic [31:0] ra, rb;
    logic        rc;
    rst_in = 1'b1; start_in = 1'b0; a_in = '0; b_in = '0; c_in = 1'b0;
    s32_start = 1'b0; s32_a = '0; s32_b = '0; s32_c = 1'b0;
    tick(); tick();
    chk("rst_busy", 64'(busy_out), 64'd0);
    chk("rst_done", 64'(done_out), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_carry", 64'(carry_out), 64'd0);
    rst_in = 1'b0;
    tick();

    add8(8'h35, 8'h1A, 1'b0, cyc, nb);
    chk("v1_lat", 64'(cyc), 64'd9);
    chk("v1_busy", 64'(nb), 64'd9);
    chk("v1_sum", 64'(sum_out), 64'h4F);
    chk("v1_carry", 64'(carry_out), 64'd0);
    tick();
    chk("v1_idle_busy", 64'(busy_out), 64'd0);
    chk("v1_idle_done", 64'(done_out), 64'd0);
    chk("v1_hold_sum", 64'(sum_out), 64'h4F);

    add8(8'hFF, 8'h01, 1'b1, cyc, nb);
    chk("v2_sum", 64'(sum_out), 64'h01);
    chk("v2_carry", 64'(carry_out), 64'd1);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("v2_ovf", 64'(overflow_out), 64'd0);
`endif
    tick();
    add8(8'h7F, 8'h01, 1'b0, cyc, nb);
    chk("v3_sum", 64'(sum_out), 64'h80);
    chk("v3_carry", 64'(carry_out), 64'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    chk("v3_ovf", 64'(overflow_out), 64'd1);
`endif
    tick();
    add8(8'hFF, 8'hFF, 1'b1, cyc, nb);
    chk("v4_res", {55'd0, carry_out, sum_out}, 64'h1FF);
    tick();

    // Start held high: accepts at cycles 0,10,20; a_in change mid-run is ignored.
    a_in = 8'h10; b_in = 8'h20; c_in = 1'b0; start_in = 1'b1;
    for (t = 1; t < 30; t++) begin
      tick();
      chk($sformatf("hold_done_c%0d", t), 64'(done_out), 64'((t % 10) == 9));
      if (done_out) chk($sformatf("hold_sum_c%0d", t), 64'(sum_out), 64'h30);
      if (t == 3) a_in = 8'hAA;
      if (t == 6) a_in = 8'h10;
    end
    start_in = 1'b0;
    tick(); tick();

    // Reset during RUN cycle 4 aborts with no done pulse.
    a_in = 8'h55; b_in = 8'h33; start_in = 1'b1;
    tick();
    start_in = 1'b0;
    tick(); tick(); tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("abort_busy", 64'(busy_out), 64'd0);
    chk("abort_sum", 64'(sum_out), 64'd0);
    chk("abort_carry", 64'(carry_out), 64'd0);
    nb = 0;
    for (t = 0; t < 12; t++) begin
      if (done_out || busy_out) nb++;
      tick();
    end
    chk("abort_quiet", 64'(nb), 64'd0);
    add8(8'h02, 8'h03, 1'b0, cyc, nb);
    chk("post_abort_lat", 64'(cyc), 64'd9);
    chk("post_abort_sum", 64'(sum_out), 64'h05);
    tick();

    // Reset wins over a simultaneous start.
    rst_in = 1'b1; start_in = 1'b1;
    tick();
    rst_in = 1'b0; start_in = 1'b0;
    chk("rst_start_busy", 64'(busy_out), 64'd0);
    tick();
    chk("rst_start_busy2", 64'(busy_out), 64'd0);

    add32(32'hFFFFFFFF, 32'h0, 1'b1, "w32_wrap");
    tick();
    add32(32'h12345678, 32'h9ABCDEF0, 1'b0, "w32_mix");
    tick();
    for (int i = 0; i < 60; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom);
      add8(ra[7:0], rb[7:0], rc, cyc, nb);
      chk($sformatf("r8_%0d", i), {55'd0, carry_out, sum_out},
          64'(ra[7:0]) + 64'(rb[7:0]) + 64'(rc));
      tick();
      add32(ra, rb, rc, $sformatf("r32_%0d", i));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
